// File: rtl/seg7_scan4.sv
// Four-digit time-multiplexed driver for a common-anode 7-segment display.
// Optional decimal-point support is enabled by defining SEG_SCAN_DP_EN.
`timescale 1ns/1ps
module seg7_scan4 #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic        en,
`ifdef SEG_SCAN_DP_EN
  input  logic [3:0]  dp_in,
  output logic        dp,
`endif
  output logic [3:0]  AN,
  output logic [6:0]  a_to_g,
  output logic        frame_done
);

  localparam int CNT_MAX = (DIV > BLANK_CYC) ? ((DIV > 2) ? DIV : 2)
                                             : ((BLANK_CYC > 2) ? BLANK_CYC : 2);
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] DIV_TC   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_TC = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     sh_value_q, sh_value_d;
  logic [3:0]      sh_den_q, sh_den_d;
  logic            sh_en_q, sh_en_d;
  logic            frame_done_q, frame_done_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            lit_d;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]      sh_dp_q, sh_dp_d;
  logic            dp_q, dp_d;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0:    hex7 = 7'b0000001;
      4'h1:    hex7 = 7'b1001111;
      4'h2:    hex7 = 7'b0010010;
      4'h3:    hex7 = 7'b0000110;
      4'h4:    hex7 = 7'b1001100;
      4'h5:    hex7 = 7'b0100100;
      4'h6:    hex7 = 7'b0100000;
      4'h7:    hex7 = 7'b0001111;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0000100;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b1100000;
      4'hC:    hex7 = 7'b0110001;
      4'hD:    hex7 = 7'b1000010;
      4'hE:    hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    sh_value_d = sh_value_q;
    sh_den_d   = sh_den_q;
    sh_en_d    = sh_en_q;
`ifdef SEG_SCAN_DP_EN
    sh_dp_d    = sh_dp_q;
`endif
    case (state_q)
      LOAD: begin
        sh_value_d = value;
        sh_den_d   = digit_en;
        sh_en_d    = en;
`ifdef SEG_SCAN_DP_EN
        sh_dp_d    = dp_in;
`endif
        idx_d      = 2'd0;
        cnt_d      = '0;
        state_d    = (BLANK_CYC == 0) ? SHOW : BLANK;
      end
      BLANK: begin
        if (cnt_q == BLANK_TC) begin
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHOW: begin
        if (cnt_q == DIV_TC) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = LOAD;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
        idx_d   = 2'd0;
      end
    endcase

    // Outputs are decoded from the next-state values and then registered,
    // so they line up with state_q without any input-to-pin path.
    frame_done_d = (state_q == LOAD);
    lit_d        = (state_d == SHOW) && sh_en_d && sh_den_d[idx_d];
    an_d         = lit_d ? ~(4'b0001 << idx_d) : 4'b1111;
    seg_d        = lit_d ? hex7(sh_value_d[{idx_d, 2'b00} +: 4]) : 7'b1111111;
`ifdef SEG_SCAN_DP_EN
    dp_d         = lit_d ? ~sh_dp_d[idx_d] : 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD;
      idx_q        <= 2'd0;
      cnt_q        <= '0;
      sh_value_q   <= 16'h0000;
      sh_den_q     <= 4'h0;
      sh_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
`ifdef SEG_SCAN_DP_EN
      sh_dp_q      <= 4'h0;
      dp_q         <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      sh_value_q   <= sh_value_d;
      sh_den_q     <= sh_den_d;
      sh_en_q      <= sh_en_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
`ifdef SEG_SCAN_DP_EN
      sh_dp_q      <= sh_dp_d;
      dp_q         <= dp_d;
`endif
    end
  end

  assign AN         = an_q;
  assign a_to_g     = seg_q;
  assign frame_done = frame_done_q;
`ifdef SEG_SCAN_DP_EN
  assign dp         = dp_q;
`endif

endmodule

// File: tb/tb_seg7_scan4.sv
// Directed self-checking bench for seg7_scan4 with DIV=4, BLANK_CYC=2.
`timescale 1ns/1ps
module tb_seg7_scan4;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic        en;
  logic [3:0]  AN;
  logic [6:0]  a_to_g;
  logic        frame_done;
`ifdef SEG_SCAN_DP_EN
  logic [3:0]  dp_in;
  logic        dp;
`endif

  int checks = 0;
  int errors = 0;

  seg7_scan4 #(.DIV(4), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .digit_en   (digit_en),
    .en         (en),
`ifdef SEG_SCAN_DP_EN
    .dp_in      (dp_in),
    .dp         (dp),
`endif
    .AN         (AN),
    .a_to_g     (a_to_g),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame offset t=0 is the frame_done cycle; each slot is 2 blank + 4 show, t=24 is LOAD.
  function automatic logic [6:0] hex_exp(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl[0]  = 7'b0000001; tbl[1]  = 7'b1001111; tbl[2]  = 7'b0010010; tbl[3]  = 7'b0000110;
    tbl[4]  = 7'b1001100; tbl[5]  = 7'b0100100; tbl[6]  = 7'b0100000; tbl[7]  = 7'b0001111;
    tbl[8]  = 7'b0000000; tbl[9]  = 7'b0000100; tbl[10] = 7'b0001000; tbl[11] = 7'b1100000;
    tbl[12] = 7'b0110001; tbl[13] = 7'b1000010; tbl[14] = 7'b0110000; tbl[15] = 7'b0111000;
    return tbl[n];
  endfunction

  function automatic bit exp_lit(input int t, input logic [3:0] den, input logic e);
    int slot;
    if (t >= 24) return 1'b0;
    slot = t / 6;
    return (t % 6 >= 2) && e && den[slot];
  endfunction

  function automatic logic [3:0] exp_an(input int t, input logic [3:0] den, input logic e);
    logic [3:0] m;
    if (!exp_lit(t, den, e)) return 4'b1111;
    m = 4'b0001 << (t / 6);
    return ~m;
  endfunction

  function automatic logic [6:0] exp_seg(input int t, input logic [15:0] v,
                                         input logic [3:0] den, input logic e);
    logic [3:0] nib;
    if (!exp_lit(t, den, e)) return 7'b1111111;
    nib = v[(t / 6) * 4 +: 4];
    return hex_exp(nib);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    value    = 16'h12AF;
    digit_en = 4'hF;
    en       = 1'b1;
`ifdef SEG_SCAN_DP_EN
    dp_in    = 4'b0010;
`endif
    repeat (3) tick();
    checks++;
    if (AN !== 4'b1111) begin
      errors++; $display("FAIL reset_an actual=%b required=%b", AN, 4'b1111);
    end
    checks++;
    if (a_to_g !== 7'b1111111) begin
      errors++; $display("FAIL reset_seg actual=%b required=%b", a_to_g, 7'b1111111);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_fd actual=%b required=%b", frame_done, 1'b0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL first_fd actual=%b required=%b", frame_done, 1'b1);
    end
  endtask

  task automatic test_frame();
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'hF, 1'b1)) begin
        errors++; $display("FAIL frame_an t=%0d actual=%b required=%b", t, AN, exp_an(t, 4'hF, 1'b1));
      end
      checks++;
      if (a_to_g !== exp_seg(t, 16'h12AF, 4'hF, 1'b1)) begin
        errors++; $display("FAIL frame_seg t=%0d actual=%b required=%b", t, a_to_g,
                           exp_seg(t, 16'h12AF, 4'hF, 1'b1));
      end
      checks++;
      if (frame_done !== (t == 0)) begin
        errors++; $display("FAIL frame_fd t=%0d actual=%b required=%b", t, frame_done, (t == 0));
      end
      tick();
    end
  endtask

  task automatic test_midframe_change();
    for (int t = 0; t < 25; t++) begin
      if (t == 9) value = 16'h0000;
      checks++;
      if (AN !== exp_an(t, 4'hF, 1'b1) || a_to_g !== exp_seg(t, 16'h12AF, 4'hF, 1'b1)) begin
        errors++; $display("FAIL mid_old t=%0d actual=%b/%b required=%b/%b", t, AN, a_to_g,
                           exp_an(t, 4'hF, 1'b1), exp_seg(t, 16'h12AF, 4'hF, 1'b1));
      end
      tick();
    end
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'hF, 1'b1) || a_to_g !== exp_seg(t, 16'h0000, 4'hF, 1'b1)
          || frame_done !== (t == 0)) begin
        errors++; $display("FAIL mid_new t=%0d actual=%b/%b/%b required=%b/%b/%b", t, AN, a_to_g,
                           frame_done, exp_an(t, 4'hF, 1'b1), exp_seg(t, 16'h0000, 4'hF, 1'b1), (t == 0));
      end
      tick();
    end
  endtask

  task automatic test_digit_en();
    value    = 16'h3210;
    digit_en = 4'b0101;
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'hF, 1'b1) || a_to_g !== exp_seg(t, 16'h0000, 4'hF, 1'b1)) begin
        errors++; $display("FAIL den_old t=%0d actual=%b/%b required=%b/%b", t, AN, a_to_g,
                           exp_an(t, 4'hF, 1'b1), exp_seg(t, 16'h0000, 4'hF, 1'b1));
      end
      tick();
    end
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'b0101, 1'b1) || a_to_g !== exp_seg(t, 16'h3210, 4'b0101, 1'b1)
          || frame_done !== (t == 0)) begin
        errors++; $display("FAIL den_new t=%0d actual=%b/%b/%b required=%b/%b/%b", t, AN, a_to_g,
                           frame_done, exp_an(t, 4'b0101, 1'b1), exp_seg(t, 16'h3210, 4'b0101, 1'b1), (t == 0));
      end
      checks++;
      if (AN[1] !== 1'b1 || AN[3] !== 1'b1) begin
        errors++; $display("FAIL den_masked t=%0d actual=%b required=1x1x", t, AN);
      end
      tick();
    end
  endtask

  task automatic test_en_off();
    en = 1'b0;
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'b0101, 1'b1) || a_to_g !== exp_seg(t, 16'h3210, 4'b0101, 1'b1)) begin
        errors++; $display("FAIL enoff_old t=%0d actual=%b/%b required=%b/%b", t, AN, a_to_g,
                           exp_an(t, 4'b0101, 1'b1), exp_seg(t, 16'h3210, 4'b0101, 1'b1));
      end
      tick();
    end
    en       = 1'b1;
    digit_en = 4'hF;
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== 4'b1111 || a_to_g !== 7'b1111111 || frame_done !== (t == 0)) begin
        errors++; $display("FAIL enoff_dark t=%0d actual=%b/%b/%b required=1111/1111111/%b", t, AN,
                           a_to_g, frame_done, (t == 0));
      end
      tick();
    end
  endtask

  task automatic test_reset_midframe();
    repeat (3) tick();
    checks++;
    if (AN !== 4'b1110 || a_to_g !== 7'b0000001) begin
      errors++; $display("FAIL rst_pre actual=%b/%b required=1110/0000001", AN, a_to_g);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (AN !== 4'b1111 || a_to_g !== 7'b1111111) begin
      errors++; $display("FAIL rst_async actual=%b/%b required=1111/1111111", AN, a_to_g);
    end
    tick();
    rst_n = 1'b1;
    tick();
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (AN !== exp_an(t, 4'hF, 1'b1) || a_to_g !== exp_seg(t, 16'h3210, 4'hF, 1'b1)
          || frame_done !== (t == 0)) begin
        errors++; $display("FAIL rst_restart t=%0d actual=%b/%b/%b required=%b/%b/%b", t, AN, a_to_g,
                           frame_done, exp_an(t, 4'hF, 1'b1), exp_seg(t, 16'h3210, 4'hF, 1'b1), (t == 0));
      end
      tick();
    end
  endtask

`ifdef SEG_SCAN_DP_EN
  task automatic test_dp();
    for (int t = 0; t < 25; t++) begin
      checks++;
      if (dp !== !(exp_lit(t, 4'hF, 1'b1) && (t / 6 == 1))) begin
        errors++; $display("FAIL dp t=%0d actual=%b required=%b", t, dp,
                           !(exp_lit(t, 4'hF, 1'b1) && (t / 6 == 1)));
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_midframe_change();
    test_digit_en();
    test_en_off();
    test_reset_midframe();
`ifdef SEG_SCAN_DP_EN
    test_dp();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
